// File: rtl/fi_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : fi_sched_if
//  Description : Control/status bundle between a fault-injection requester
//                and the fi_sched scheduler.
//                master : drives start/abort/cfg_*, observes injection status
//                slave  : the scheduler (consumes cfg, produces inj_*/status)
//  Signals     : start, abort          - arm / cancel requests
//                cfg_delay [DLY_W]     - cycles from start to first injection
//                cfg_duration [DUR_W]  - injected cycles (0 behaves as 1)
//                cfg_target [2]        - 0=q1, 1=q2, 2=q3, 3=invalid
//                cfg_mode [2]          - 00 sa0, 01 sa1, 10 flip, 11 invalid
//                inj_en [3], inj_val, inj_flip - force controls
//                busy, done, err, fault_count [8] - status
//  Revision    : 1.0 - initial release
// ============================================================================
interface fi_sched_if #(
    parameter int DLY_W = 16,
    parameter int DUR_W = 8
);
    logic             start;
    logic             abort;
    logic [DLY_W-1:0] cfg_delay;
    logic [DUR_W-1:0] cfg_duration;
    logic [1:0]       cfg_target;
    logic [1:0]       cfg_mode;
    logic [2:0]       inj_en;
    logic             inj_val;
    logic             inj_flip;
    logic             busy;
    logic             done;
    logic             err;
    logic [7:0]       fault_count;

    modport master (
        output start, abort, cfg_delay, cfg_duration, cfg_target, cfg_mode,
        input  inj_en, inj_val, inj_flip, busy, done, err, fault_count
    );

    modport slave (
        input  start, abort, cfg_delay, cfg_duration, cfg_target, cfg_mode,
        output inj_en, inj_val, inj_flip, busy, done, err, fault_count
    );
endinterface
`default_nettype wire

// File: rtl/fi_sched.sv
`default_nettype none
// ============================================================================
//  Module      : fi_sched
//  Description : Fault-injection scheduler. A start request with a valid
//                configuration arms one injection: after cfg_delay cycles
//                the selected datapath flop is forced (stuck-at-0/1) or
//                inverted (bit-flip) for max(cfg_duration,1) cycles, then a
//                one-cycle done pulse is issued and the completed-injection
//                counter (saturating at 255) advances.
//  Ports       : clk   - rising-edge clock
//                reset - asynchronous active-low reset
//                bus   - fi_sched_if.slave (requests, config, force controls,
//                        busy/done/err status and fault_count)
//  Revision    : 1.0 - initial release
// ============================================================================
module fi_sched #(
    parameter int DLY_W = 16,   // must match the connected interface
    parameter int DUR_W = 8     // must match the connected interface
) (
    input  wire logic    clk,
    input  wire logic    reset,
    fi_sched_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        INJECT = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           state_q,    state_d;
    logic [DLY_W-1:0] dly_q,      dly_d;       // latched config
    logic [DUR_W-1:0] dur_q,      dur_d;
    logic [1:0]       tgt_q,      tgt_d;
    logic [1:0]       mode_q,     mode_d;
    logic [DLY_W-1:0] dly_cnt_q,  dly_cnt_d;   // remaining ARM cycles
    logic [DUR_W-1:0] dur_cnt_q,  dur_cnt_d;   // remaining INJECT cycles
    logic [2:0]       inj_en_q,   inj_en_d;
    logic             inj_val_q,  inj_val_d;
    logic             inj_flip_q, inj_flip_d;
    logic             busy_q,     busy_d;
    logic             done_q,     done_d;
    logic             err_q,      err_d;
    logic [7:0]       fcnt_q,     fcnt_d;

    logic             cfg_bad;
    assign cfg_bad = (bus.cfg_target == 2'd3) || (bus.cfg_mode == 2'b11);

    always_comb begin
        state_d    = state_q;
        dly_d      = dly_q;
        dur_d      = dur_q;
        tgt_d      = tgt_q;
        mode_d     = mode_q;
        dly_cnt_d  = dly_cnt_q;
        dur_cnt_d  = dur_cnt_q;
        fcnt_d     = fcnt_q;
        err_d      = 1'b0;

        case (state_q)
            IDLE: begin
                // abort outranks start: nothing happens, not even err
                if (!bus.abort && bus.start) begin
                    if (cfg_bad) begin
                        err_d = 1'b1;
                    end else begin
                        dly_d  = bus.cfg_delay;
                        dur_d  = bus.cfg_duration;
                        tgt_d  = bus.cfg_target;
                        mode_d = bus.cfg_mode;
                        if (bus.cfg_delay != '0) begin
                            state_d   = ARM;
                            dly_cnt_d = bus.cfg_delay;
                        end else begin
                            state_d   = INJECT;
                            dur_cnt_d = (bus.cfg_duration == '0) ? DUR_W'(1)
                                                                 : bus.cfg_duration;
                        end
                    end
                end
            end
            ARM: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (dly_cnt_q <= DLY_W'(1)) begin
                    state_d   = INJECT;
                    dur_cnt_d = (dur_q == '0) ? DUR_W'(1) : dur_q;
                end else begin
                    dly_cnt_d = dly_cnt_q - DLY_W'(1);
                end
            end
            INJECT: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (dur_cnt_q <= DUR_W'(1)) begin
                    state_d = DONE;
                    if (fcnt_q != 8'hFF) begin
                        fcnt_d = fcnt_q + 8'd1;
                    end
                end else begin
                    dur_cnt_d = dur_cnt_q - DUR_W'(1);
                end
            end
            default: begin  // DONE: always one cycle, abort or not
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they register in step
        // with the state itself.
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == DONE);
        inj_en_d   = 3'b000;
        inj_val_d  = 1'b0;
        inj_flip_d = 1'b0;
        if (state_d == INJECT) begin
            inj_en_d   = 3'b001 << tgt_d;
            inj_flip_d = mode_d[1];
            inj_val_d  = mode_d[0] & ~mode_d[1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            dly_q      <= '0;
            dur_q      <= '0;
            tgt_q      <= '0;
            mode_q     <= '0;
            dly_cnt_q  <= '0;
            dur_cnt_q  <= '0;
            inj_en_q   <= '0;
            inj_val_q  <= 1'b0;
            inj_flip_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            fcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            dly_q      <= dly_d;
            dur_q      <= dur_d;
            tgt_q      <= tgt_d;
            mode_q     <= mode_d;
            dly_cnt_q  <= dly_cnt_d;
            dur_cnt_q  <= dur_cnt_d;
            inj_en_q   <= inj_en_d;
            inj_val_q  <= inj_val_d;
            inj_flip_q <= inj_flip_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            fcnt_q     <= fcnt_d;
        end
    end

    assign bus.inj_en      = inj_en_q;
    assign bus.inj_val     = inj_val_q;
    assign bus.inj_flip    = inj_flip_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;
    assign bus.fault_count = fcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fi_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fi_sched
//  Description : Self-checking bench for fi_sched. Each scenario pushes the
//                expected per-cycle output word into a scoreboard queue as
//                its stimulus is driven; the words are popped and compared
//                against the DUT outputs sampled at the falling edge.
//                Output word = {busy, inj_en[2:0], inj_val, inj_flip, done,
//                err, fault_count[7:0]}.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fi_sched;

    localparam int C_DLY_W = 16;
    localparam int C_DUR_W = 8;

    logic clk;
    logic reset;

    fi_sched_if #(.DLY_W(C_DLY_W), .DUR_W(C_DUR_W)) bus ();

    fi_sched #(.DLY_W(C_DLY_W), .DUR_W(C_DUR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          exp_fc  = 0;
    logic [15:0] exp_q[$];

    task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %04h expected %04h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] pack(input bit busy, input logic [2:0] en,
                                         input bit val, input bit flip,
                                         input bit done, input bit err, input int fc);
        logic [7:0] f;
        f = fc[7:0];
        return {busy, en, val, flip, done, err, f};
    endfunction

    function automatic logic [15:0] outvec();
        return {bus.busy, bus.inj_en, bus.inj_val, bus.inj_flip,
                bus.done, bus.err, bus.fault_count};
    endfunction

    task automatic drive_cfg(input int dly, input int dur, input int tgt, input int mode);
        bus.cfg_delay    = 16'(dly);
        bus.cfg_duration = 8'(dur);
        bus.cfg_target   = 2'(tgt);
        bus.cfg_mode     = 2'(mode);
    endtask

    // One start request. abort_cyc/restart_cyc (0 = unused) name the cycle
    // after the start edge during which abort or a second start is held.
    task automatic run(input string tag, input int dly, input int dur,
                       input int tgt, input int mode,
                       input int abort_cyc, input int restart_cyc);
        int         d;
        logic [2:0] en;
        bit         val, flip;
        logic [15:0] idle;
        if (tgt == 3 || mode == 3) begin
            exp_q.push_back(pack(0, 3'b000, 0, 0, 0, 1, exp_fc));
            exp_q.push_back(pack(0, 3'b000, 0, 0, 0, 0, exp_fc));
        end else begin
            d    = (dur == 0) ? 1 : dur;
            en   = 3'b001 << tgt;
            val  = (mode == 1);
            flip = (mode == 2);
            for (int c = 1; c <= dly + d + 2; c++) begin
                idle = pack(0, 3'b000, 0, 0, 0, 0, exp_fc);
                if (abort_cyc > 0 && c == abort_cyc + 1) begin
                    exp_q.push_back(idle);
                    break;
                end
                if (c <= dly)
                    exp_q.push_back(pack(1, 3'b000, 0, 0, 0, 0, exp_fc));
                else if (c <= dly + d)
                    exp_q.push_back(pack(1, en, val, flip, 0, 0, exp_fc));
                else if (c == dly + d + 1) begin
                    if (exp_fc != 255) exp_fc++;
                    exp_q.push_back(pack(1, 3'b000, 0, 0, 1, 0, exp_fc));
                end else
                    exp_q.push_back(pack(0, 3'b000, 0, 0, 0, 0, exp_fc));
            end
        end

        @(posedge clk); #1;
        drive_cfg(dly, dur, tgt, mode);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int c = 1; exp_q.size() > 0; c++) begin
            if (c == abort_cyc) bus.abort = 1'b1;
            if (c == restart_cyc) begin
                bus.start = 1'b1;
                drive_cfg(1, 7, 0, 0);
            end
            @(negedge clk);
            chk(tag, outvec(), exp_q.pop_front());
            @(posedge clk); #1;
            bus.abort = 1'b0;
            bus.start = 1'b0;
        end
    endtask

    // Start an injection, follow it for n cycles, then pull reset low in
    // the middle of the low clock phase and check outputs before any edge.
    task automatic reset_mid(input string tag, input int dly, input int dur,
                             input int tgt, input int n);
        @(posedge clk); #1;
        drive_cfg(dly, dur, tgt, 1);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int c = 1; c <= n; c++) begin
            if (c <= dly) exp_q.push_back(pack(1, 3'b000, 0, 0, 0, 0, exp_fc));
            else          exp_q.push_back(pack(1, 3'b001 << tgt, 1, 0, 0, 0, exp_fc));
            @(negedge clk);
            chk({tag, "_pre"}, outvec(), exp_q.pop_front());
            if (c < n) begin
                @(posedge clk); #1;
            end
        end
        #1 reset = 1'b0;
        exp_fc = 0;
        #1;
        exp_q.push_back(pack(0, 3'b000, 0, 0, 0, 0, 0));
        chk({tag, "_async"}, outvec(), exp_q.pop_front());
        #1 reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            exp_q.push_back(pack(0, 3'b000, 0, 0, 0, 0, 0));
            @(negedge clk);
            chk({tag, "_noresume"}, outvec(), exp_q.pop_front());
        end
    endtask

    initial begin
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        drive_cfg(0, 0, 0, 0);
        #2;
        exp_q.push_back(pack(0, 3'b000, 0, 0, 0, 0, 0));
        chk("reset_state", outvec(), exp_q.pop_front());
        @(negedge clk);
        reset = 1'b1;

        run("d3_dur2_q2_sa1",   3, 2, 1, 1, 0, 0);
        run("d0_dur0_q3_flip",  0, 0, 2, 2, 0, 0);
        run("d1_dur3_q1_sa0",   1, 3, 0, 0, 0, 0);
        run("bad_target",       2, 2, 3, 0, 0, 0);
        run("bad_mode",         2, 2, 0, 3, 0, 0);
        run("abort_inject2",    2, 5, 1, 1, 4, 0);
        run("abort_arm",        4, 2, 2, 0, 2, 0);
        run("restart_in_arm",   3, 2, 2, 2, 0, 2);

        // abort together with start while idle: no err, no arming
        @(posedge clk); #1;
        drive_cfg(0, 1, 0, 1);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        exp_q.push_back(pack(0, 3'b000, 0, 0, 0, 0, exp_fc));
        exp_q.push_back(pack(0, 3'b000, 0, 0, 0, 0, exp_fc));
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("abort_and_start", outvec(), exp_q.pop_front());
        end

        reset_mid("rst_mid_arm",    6, 3, 0, 3);
        reset_mid("rst_mid_inject", 2, 5, 2, 4);

        for (int i = 0; i < 260; i++) begin
            run("saturate", 0, 1, i % 3, i % 3, 0, 0);
        end
        exp_q.push_back(pack(0, 3'b000, 0, 0, 0, 0, 255));
        @(negedge clk);
        chk("fault_count_255", outvec(), exp_q.pop_front());

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
